// File: rtl/scan_bridge_pkg.sv
// scan_bridge shared types: FSM states, chain field offsets, status bit indices.
package scan_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int OFF_WEN  = 0;
    localparam int OFF_REN  = 1;
    localparam int OFF_ADDR = 2;

    localparam int STAT_DONE = 0;
    localparam int STAT_TMO  = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_N    = 3;

    function automatic int off_wdata(input int aw);
        return aw + 2;
    endfunction

    function automatic int off_rdata(input int aw, input int dw);
        return aw + dw + 2;
    endfunction

    function automatic int off_stat(input int aw, input int dw);
        return aw + 2 * dw + 2;
    endfunction

    function automatic int chain_w(input int aw, input int dw, input int pw);
        return aw + 2 * dw + 2 + STAT_N + pw;
    endfunction

endpackage

// File: rtl/scan_shift_chain.sv
// Serial scan register with parallel load; load has priority over shift.
module scan_shift_chain
    import scan_bridge_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic         i_sin,
    input  logic [W-1:0] i_pin,
    output logic         o_sout,
    output logic [W-1:0] o_pout
);

    logic [W-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else if (i_load) begin
            r_chain <= i_pin;
        end else if (i_shift) begin
            r_chain <= {i_sin, r_chain[W-1:1]};
        end
    end

    assign o_sout = r_chain[0];
    assign o_pout = r_chain;

endmodule

// File: rtl/scan_bridge.sv
// Scan-chain command bridge to a valid/ready static memory port.
// Define SCAN_BRIDGE_PARITY_EN to add an even-parity MSB to the chain.
module scan_bridge
    import scan_bridge_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_shift_en,
    input  logic              scan_data_in,
    output logic              scan_data_out,
    input  logic              scan_load_chain,
    input  logic              scan_load_chip,
    output logic              static_wen,
    output logic              static_ren,
    output logic [ADDR_W-1:0] static_addr,
    output logic [DATA_W-1:0] static_wdata,
    output logic              static_valid,
    input  logic              static_ready,
    input  logic [DATA_W-1:0] static_rdata
);

`ifdef SCAN_BRIDGE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    localparam int CHAIN_W = chain_w(ADDR_W, DATA_W, PAR_W);
    localparam int O_WD    = off_wdata(ADDR_W);
    localparam int O_RD    = off_rdata(ADDR_W, DATA_W);
    localparam int O_ST    = off_stat(ADDR_W, DATA_W);
    localparam int CMD_W   = O_RD;
    localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_wen;
    logic                r_ren;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done;
    logic                r_tmo;
    logic                r_ovr;
    logic [CNT_W-1:0]    r_cnt;

    logic [CHAIN_W-1:0]  w_chain;
    logic [CHAIN_W-1:0]  w_pin;
    logic                w_par_ok;
    logic                w_latch;
    logic                w_launch;
    logic                w_reject;
    logic                w_busy_ld;
    logic                w_ready_hit;
    logic                w_tmo_hit;
    logic                w_unused;

    always_comb begin
        w_pin = '0;
        w_pin[OFF_WEN]                = r_wen;
        w_pin[OFF_REN]                = r_ren;
        w_pin[OFF_ADDR +: ADDR_W]     = r_addr;
        w_pin[O_WD +: DATA_W]         = r_wdata;
        w_pin[O_RD +: DATA_W]         = r_rdata;
        w_pin[O_ST + STAT_DONE]       = r_done;
        w_pin[O_ST + STAT_TMO]        = r_tmo;
        w_pin[O_ST + STAT_OVR]        = r_ovr;
`ifdef SCAN_BRIDGE_PARITY_EN
        w_pin[CHAIN_W-1] = ^{r_wdata, r_addr, r_ren, r_wen};
`endif
    end

    scan_shift_chain #(
        .W(CHAIN_W)
    ) u_chain (
        .clk     (clk),
        .rst     (rst),
        .i_load  (scan_load_chain),
        .i_shift (scan_shift_en),
        .i_sin   (scan_data_in),
        .i_pin   (w_pin),
        .o_sout  (scan_data_out),
        .o_pout  (w_chain)
    );

    // Readback-only fields of the chain never feed the command path.
    assign w_unused = ^w_chain[CHAIN_W-1:CMD_W];

`ifdef SCAN_BRIDGE_PARITY_EN
    assign w_par_ok = ~(^w_chain[CMD_W-1:0] ^ w_chain[CHAIN_W-1]);
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_latch     = (r_state == ST_IDLE) & scan_load_chip & w_par_ok;
    assign w_launch    = w_latch & (w_chain[OFF_WEN] | w_chain[OFF_REN]);
    assign w_reject    = (r_state == ST_IDLE) & scan_load_chip & ~w_par_ok;
    assign w_busy_ld   = (r_state != ST_IDLE) & scan_load_chip;
    assign w_ready_hit = (r_state == ST_REQ) & static_ready;
    assign w_tmo_hit   = (TIMEOUT_CYC > 0) & (r_state == ST_REQ) &
                         ~static_ready & (r_cnt >= CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_launch) w_state_nxt = ST_REQ;
            ST_REQ:  if (w_ready_hit | w_tmo_hit) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write wins when both command bits are set.
    always_comb begin
        static_valid = (r_state == ST_REQ);
        static_wen   = r_wen;
        static_ren   = r_ren & ~r_wen;
        static_addr  = r_addr;
        static_wdata = r_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
            r_ovr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_latch) begin
                r_wen   <= w_chain[OFF_WEN];
                r_ren   <= w_chain[OFF_REN];
                r_addr  <= w_chain[OFF_ADDR +: ADDR_W];
                r_wdata <= w_chain[O_WD +: DATA_W];
            end
            if (w_busy_ld | w_reject) begin
                r_ovr <= 1'b1;
            end
            if (r_state == ST_REQ) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_ready_hit & r_ren & ~r_wen) begin
                    r_rdata <= static_rdata;
                end
                if (w_tmo_hit) begin
                    r_tmo <= 1'b1;
                end
            end
            if (r_state == ST_DONE) begin
                r_done <= 1'b1;
            end
            if (w_launch) begin
                r_done <= 1'b0;
                r_tmo  <= 1'b0;
                r_ovr  <= 1'b0;
                r_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_scan_bridge.sv
// Randomised bench for scan_bridge against a transaction-level model.
module tb_scan_bridge;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 8;
`ifdef SCAN_BRIDGE_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int CW   = 5 + AW + 2 * DW + PW;
    localparam int ORD  = AW + DW + 2;
    localparam int OST  = AW + 2 * DW + 2;
    localparam int CMDW = AW + DW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scan_shift_en = 1'b0;
    logic          scan_data_in = 1'b0;
    logic          scan_data_out;
    logic          scan_load_chain = 1'b0;
    logic          scan_load_chip = 1'b0;
    logic          static_wen;
    logic          static_ren;
    logic [AW-1:0] static_addr;
    logic [DW-1:0] static_wdata;
    logic          static_valid;
    logic          static_ready = 1'b0;
    logic [DW-1:0] static_rdata = '0;

    scan_bridge #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .scan_shift_en   (scan_shift_en),
        .scan_data_in    (scan_data_in),
        .scan_data_out   (scan_data_out),
        .scan_load_chain (scan_load_chain),
        .scan_load_chip  (scan_load_chip),
        .static_wen      (static_wen),
        .static_ren      (static_ren),
        .static_addr     (static_addr),
        .static_wdata    (static_wdata),
        .static_valid    (static_valid),
        .static_ready    (static_ready),
        .static_rdata    (static_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic          m_wen = 1'b0;
    logic          m_ren = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_done = 1'b0;
    logic          m_tmo = 1'b0;
    logic          m_ovr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [CW-1:0] mk_frame(input logic wen, input logic ren,
                                               input logic [AW-1:0] a,
                                               input logic [DW-1:0] wd);
        logic [CW-1:0] v;
        for (int i = 0; i < CW; i++) v[i] = rbit();
        v[0] = wen;
        v[1] = ren;
        v[AW+1:2] = a;
        v[AW+DW+1:AW+2] = wd;
`ifdef SCAN_BRIDGE_PARITY_EN
        v[CW-1] = ^v[CMDW-1:0];
`endif
        return v;
    endfunction

    function automatic logic [CW-1:0] exp_chain();
        logic [CW-1:0] v;
        v = '0;
        v[0] = m_wen;
        v[1] = m_ren;
        v[AW+1:2] = m_addr;
        v[AW+DW+1:AW+2] = m_wdata;
        v[ORD+DW-1:ORD] = m_rdata;
        v[OST] = m_done;
        v[OST+1] = m_tmo;
        v[OST+2] = m_ovr;
`ifdef SCAN_BRIDGE_PARITY_EN
        v[CW-1] = ^v[CMDW-1:0];
`endif
        return v;
    endfunction

    task automatic shift_frame(input logic [CW-1:0] v);
        for (int i = 0; i < CW; i++) begin
            @(negedge clk);
            scan_shift_en = 1'b1;
            scan_data_in  = v[i];
        end
    endtask

    // Load and shift asserted together: the load must win.
    task automatic readback(input string tag);
        logic [CW-1:0] got;
        logic [CW-1:0] e;
        e = exp_chain();
        @(negedge clk);
        scan_load_chain = 1'b1;
        scan_shift_en   = 1'b1;
        scan_data_in    = rbit();
        for (int i = 0; i < CW; i++) begin
            @(negedge clk);
            scan_load_chain = 1'b0;
            got[i] = scan_data_out;
            scan_data_in = 1'b0;
        end
        scan_shift_en = 1'b0;
        chk({tag, "_chain"}, 64'(got), 64'(e));
        chk({tag, "_rdata"}, 64'(got[ORD+DW-1:ORD]), 64'(m_rdata));
        chk({tag, "_stat"}, 64'(got[OST+2:OST]), 64'({m_ovr, m_tmo, m_done}));
    endtask

    task automatic run_txn(input logic wen, input logic ren,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int d, input int ovr_at,
                           input logic [DW-1:0] rd, input logic flip,
                           input string tag);
        logic [CW-1:0] fr;
        logic launch;
        int cnt;
        int ev;
        fr = mk_frame(wen, ren, a, wd);
`ifdef SCAN_BRIDGE_PARITY_EN
        if (flip) fr[CW-1] = ~fr[CW-1];
`endif
        launch = !flip && (wen || ren);
        ev = !launch ? 0 : ((d + 1 <= TMO) ? d + 1 : TMO);
        shift_frame(fr);
        @(negedge clk);
        scan_load_chip = 1'b1;
        scan_shift_en  = rbit();
        scan_data_in   = rbit();
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            scan_load_chip = 1'b0;
            scan_shift_en  = 1'b0;
            static_ready   = 1'b0;
            if (c == 0) chk({tag, "_lat"}, 64'(static_valid), 64'(launch));
            if (static_valid) begin
                cnt++;
                chk({tag, "_cmd"},
                    64'({static_wen, static_ren, static_addr, static_wdata}),
                    64'({wen, ren & ~wen, a, wd}));
                if (cnt < ovr_at) begin
                    scan_shift_en = 1'b1;
                    scan_data_in  = rbit();
                end
                if (cnt == ovr_at) scan_load_chip = 1'b1;
                if (cnt == d + 1) static_ready = 1'b1;
                static_rdata = (cnt == d + 1) ? rd : DW'($urandom);
            end else begin
                static_ready = rbit();
                static_rdata = DW'($urandom);
            end
        end
        static_ready = 1'b0;
        chk({tag, "_vcnt"}, 64'(cnt), 64'(ev));
        if (!flip) begin
            m_wen = wen;
            m_ren = ren;
            m_addr = a;
            m_wdata = wd;
        end else begin
            m_ovr = 1'b1;
        end
        if (launch) begin
            m_done = 1'b1;
            m_tmo  = (d + 1 > TMO);
            m_ovr  = (ovr_at > 0);
            if (d + 1 <= TMO && ren && !wen) m_rdata = rd;
        end
        readback(tag);
    endtask

    initial begin
        logic [CW-1:0] fr;
        logic w;
        logic r;
        int d;
        int ev;
        int oa;

        repeat (2) @(negedge clk);
        chk("reset_out",
            64'({static_valid, static_wen, static_ren, static_addr,
                 static_wdata, scan_data_out}), 64'(0));
        rst = 1'b0;
        readback("reset");

        run_txn(1'b1, 1'b0, 16'h1234, 16'hBEEF, 3, 0, 16'h0000, 1'b0, "wr");
        run_txn(1'b0, 1'b1, 16'h00A5, 16'h0000, 0, 0, 16'hC0DE, 1'b0, "rd");
        run_txn(1'b1, 1'b0, 16'h5A5A, 16'h0F0F, 20, 0, 16'h0000, 1'b0, "tmo");
        run_txn(1'b0, 1'b1, 16'h0042, 16'h0000, 1, 0, 16'h7777, 1'b0, "clr");
        run_txn(1'b0, 1'b1, 16'h3C3C, 16'h0000, 5, 2, 16'h9999, 1'b0, "ovr");
        run_txn(1'b1, 1'b1, 16'hAAAA, 16'h5555, 2, 0, 16'h1111, 1'b0, "both");
        run_txn(1'b0, 1'b0, 16'h0BAD, 16'hF00D, 0, 0, 16'h2222, 1'b0, "idle");
        run_txn(1'b0, 1'b1, 16'h0007, 16'h0000, 7, 0, 16'h8888, 1'b0, "edge");
`ifdef SCAN_BRIDGE_PARITY_EN
        run_txn(1'b1, 1'b0, 16'h4321, 16'h1357, 1, 0, 16'h0000, 1'b1, "par");
`endif

        for (int n = 0; n < 20; n++) begin
            w  = rbit();
            r  = rbit();
            d  = $urandom_range(0, 10);
            ev = (d + 1 <= TMO) ? d + 1 : TMO;
            oa = ((w || r) && rbit()) ? $urandom_range(1, ev) : 0;
            run_txn(w, r, AW'($urandom), DW'($urandom), d, oa,
                    DW'($urandom), 1'b0, "rand");
        end

        fr = mk_frame(1'b1, 1'b0, 16'hFACE, 16'hCAFE);
        shift_frame(fr);
        @(negedge clk);
        scan_load_chip = 1'b1;
        scan_shift_en  = 1'b0;
        @(negedge clk);
        scan_load_chip = 1'b0;
        chk("rst_pre_valid", 64'(static_valid), 64'(1));
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_async",
               64'({static_valid, static_wen, static_ren, static_addr,
                    static_wdata, scan_data_out}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        m_wen = 1'b0;
        m_ren = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_done = 1'b0;
        m_tmo = 1'b0;
        m_ovr = 1'b0;
        readback("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_bridge.md
Name: scan_bridge

Overview:
- Parametrised, clocked successor of the SIMD engine's two-phase latch scan chain.
- Shifts a command frame in and out over the pad-side scan pins and latches it into command registers on `scan_load_chip`.
- Autonomously runs a valid/ready read or write transaction on the static memory port, with timeout supervision.
- Loads result data plus sticky status back into the chain on `scan_load_chain`.

Parameters:
- ADDR_W, 16, static address width (address, lane_id and i/d_sel fields packed inside).
- DATA_W, 16, static read and write data width.
- TIMEOUT_CYC, 256, cycles `static_valid` may wait for `static_ready`; 0 disables the timeout.
- CHAIN_W, derived = 5+ADDR_W+2*DATA_W (+1 with parity); default 53. Localparam, not overridable.

Ports:
- clk  in  1  single block clock.
- rst  in  1  asynchronous active-high reset.
- scan_shift_en  in  1  shift chain one bit this cycle; pre-synchronised to clk.
- scan_data_in  in  1  serial data into the chain MSB.
- scan_data_out  out  1  chain bit 0.
- scan_load_chain  in  1  one-cycle pulse: parallel-load the chain from the command/status registers.
- scan_load_chip  in  1  one-cycle pulse: update the command registers from the chain and launch a transaction.
- static_wen  out  1  write command.
- static_ren  out  1  read command.
- static_addr  out  ADDR_W  address.
- static_wdata  out  DATA_W  write data.
- static_valid  out  1  transaction request.
- static_ready  in  1  target accepts or completes the request this cycle.
- static_rdata  in  DATA_W  read data, valid when `static_valid && static_ready`.

Behaviour:
- Chain layout, LSB first:
  - [0] wen, [1] ren
  - [ADDR_W+1:2] addr
  - next DATA_W bits: wdata
  - next DATA_W bits: rdata
  - then done, timeout, overrun
  - parity at MSB when the optional feature is enabled.
- Reset: all outputs and registers are 0; FSM is IDLE; `scan_data_out` = 0.
- Chain priority per cycle: `scan_load_chain` > `scan_shift_en` > hold.
  - Shift is `{scan_data_in, chain[CHAIN_W-1:1]}`.
  - Load captures the current register values, not the values being written this same cycle.
- `scan_load_chip` samples the chain as it stood before this cycle's load/shift update.
- FSM states are IDLE, REQ, DONE.
- IDLE + `scan_load_chip`:
  - Latch wen, ren, addr and wdata.
  - If wen|ren, go to REQ, clear done/timeout, and assert `static_valid` from the next cycle (latency 1).
  - If wen=ren=0, only latch; stay IDLE.
  - If wen=ren=1, write wins; `static_ren` is driven 0.
- REQ:
  - `static_valid`=1 and all command outputs are held stable.
  - On a cycle with `static_ready`=1: capture `static_rdata` if a read (rdata unchanged for a write), go to DONE, drop valid next cycle.
  - If TIMEOUT_CYC>0 and the wait counter reaches TIMEOUT_CYC without ready: set timeout=1, go to DONE, drop valid.
  - Wait counter is $clog2(TIMEOUT_CYC+1) bits, saturating, cleared on entry to REQ.
- DONE: set done=1 (on a timeout this is in addition to timeout=1); go to IDLE in 1 cycle.
- `scan_load_chip` while in REQ or DONE: ignored; command registers are unchanged and the sticky overrun bit is set.
- Sticky bits (done, timeout, overrun) clear only on the next accepted launch or on reset.
- `static_ready` outside REQ is ignored.
- Reset asserted mid-transaction: `static_valid` falls asynchronously; the transaction is abandoned.

Optional Feature:
- Macro: SCAN_BRIDGE_PARITY_EN.
- When defined:
  - CHAIN_W gains an MSB parity bit.
  - At `scan_load_chip`, even parity over bits [ADDR_W+DATA_W+1:0] plus the parity bit must be 0.
  - On mismatch: no latch, no launch, and the overrun bit is set as a reject flag.
  - On `scan_load_chain`, the parity bit loads as the XOR of the loaded command bits.
- When undefined: no parity bit and no check.

Decomposition:
- Package `scan_bridge_pkg`:
  - FSM state enum (IDLE, REQ, DONE).
  - Functions returning field offsets from ADDR_W/DATA_W.
  - Status bit index constants.
- One sub-module, `scan_shift_chain`: parametrised CHAIN_W shift/parallel-load register with priority logic, serial in/out and parallel in/out.

Test Plan:
- Write: shift frame wen=1, addr=0x1234, wdata=0xBEEF; pulse `scan_load_chip`; ready after 3 cycles -> valid high for exactly 4 cycles with addr/wdata stable; done=1 on readback.
- Read: ren=1, addr=0x00A5; ready with rdata=0xC0DE on the 1st REQ cycle -> `scan_load_chain` then 53 shifts yield rdata=0xC0DE, done=1, timeout=0.
- Timeout: TIMEOUT_CYC=8, ready never asserted -> valid drops after 8 cycles; timeout=1, done=1; next launch clears both.
- Overrun: second `scan_load_chip` while in REQ -> outputs unchanged; overrun=1 on readback.
- Priority: `scan_load_chain` and `scan_shift_en` together -> load wins, and `scan_data_out` equals the wen value next cycle; wen=ren=1 -> `static_ren`=0.
- Reset mid-REQ, plus a parity frame with one flipped bit under SCAN_BRIDGE_PARITY_EN:
  - Reset mid-REQ -> all outputs 0 immediately.
  - Flipped parity -> no valid; overrun=1.
